// File: rtl/mc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_if
// Purpose  : Control bundle between the multi-cycle MIPS controller and its
//            datapath: decoded instruction fields and flags inbound,
//            write strobes and mux selects outbound.
// Revision : 1.0
// ============================================================================
interface mc_ctrl_if;
   // Instruction fields and datapath flags
   logic [5:0] op;
   logic [5:0] func;
   logic       zero;
   logic       lez;
   // Write strobes
   logic       pc_wr;
   logic       ir_wr;
   logic       reg_wr;
   logic       mem_wr;
   // Mux selects and ALU control
   logic [1:0] reg_dst;
   logic       alu_src;
   logic       ext_op;
   logic [2:0] alu_op;
   logic [1:0] mem_to_reg;
   logic [1:0] npc_sel;
   // Status
   logic [2:0] state;
   logic       instr_done;

   // Controller side
   modport master (
      input  op, func, zero, lez,
      output pc_wr, ir_wr, reg_wr, mem_wr,
      output reg_dst, alu_src, ext_op, alu_op, mem_to_reg, npc_sel,
      output state, instr_done
   );

   // Datapath side
   modport slave (
      output op, func, zero, lez,
      input  pc_wr, ir_wr, reg_wr, mem_wr,
      input  reg_dst, alu_src, ext_op, alu_op, mem_to_reg, npc_sel,
      input  state, instr_done
   );
endinterface
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl
// Purpose  : Multi-cycle main controller for the MIPS datapath. Sequences
//            each instruction through IF/ID/EXE/MEM/WB and drives every
//            write strobe and mux select. Unsupported encodings run as nops.
// Revision : 1.0
// ============================================================================
module mc_ctrl #(
   parameter int MEM_WAIT = 0
) (
   input  wire logic     clk,
   input  wire logic     reset,
   mc_ctrl_if.master     bus
);

   // State encoding
   localparam logic [2:0] S_IF  = 3'd0;
   localparam logic [2:0] S_ID  = 3'd1;
   localparam logic [2:0] S_EXE = 3'd2;
   localparam logic [2:0] S_MEM = 3'd3;
   localparam logic [2:0] S_WB  = 3'd4;

   // Opcodes and R-type function codes
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BLEZ  = 6'b000110;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] FN_ADDU  = 6'b100001;
   localparam logic [5:0] FN_SUBU  = 6'b100011;
   localparam logic [5:0] FN_JR    = 6'b001000;

   // Wait counter is at least one bit wide even when MEM_WAIT is zero
   localparam int              WAIT_W    = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT);

   logic [2:0]        state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;

   // Instruction decode (op/func are held stable by IR from ID onwards)
   logic is_r, is_addu, is_subu, is_jr, is_ori, is_lui;
   logic is_lw, is_sw, is_beq, is_blez, is_j, is_jal;
   logic is_known, is_ralu, mem_last;

   assign is_r     = (bus.op == OP_RTYPE);
   assign is_addu  = is_r && (bus.func == FN_ADDU);
   assign is_subu  = is_r && (bus.func == FN_SUBU);
   assign is_jr    = is_r && (bus.func == FN_JR);
   assign is_ralu  = is_addu || is_subu;
   assign is_ori   = (bus.op == OP_ORI);
   assign is_lui   = (bus.op == OP_LUI);
   assign is_lw    = (bus.op == OP_LW);
   assign is_sw    = (bus.op == OP_SW);
   assign is_beq   = (bus.op == OP_BEQ);
   assign is_blez  = (bus.op == OP_BLEZ);
   assign is_j     = (bus.op == OP_J);
   assign is_jal   = (bus.op == OP_JAL);
   assign is_known = is_ralu || is_jr || is_ori || is_lui || is_lw || is_sw ||
                     is_beq || is_blez || is_j || is_jal;

   // Final cycle of the MEM phase once the wait counter has caught up
   assign mem_last = (wait_q == WAIT_LAST);

   // State and wait-counter registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IF;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   // Next-state and wait-counter logic
   always_comb begin
      state_d = S_IF;
      wait_d  = '0;
      case (state_q)
         S_IF: state_d = S_ID;
         S_ID: begin
            if (is_j || is_jal || is_jr || !is_known)
               state_d = S_IF;
            else
               state_d = S_EXE;
         end
         S_EXE: begin
            if (is_lw || is_sw)
               state_d = S_MEM;
            else if (is_ralu || is_ori || is_lui)
               state_d = S_WB;
            else
               state_d = S_IF;
         end
         S_MEM: begin
            if (!mem_last) begin
               state_d = S_MEM;
               wait_d  = wait_q + 1'b1;
            end else if (is_lw) begin
               state_d = S_WB;
            end else begin
               state_d = S_IF;
            end
         end
         S_WB:    state_d = S_IF;
         default: state_d = S_IF;
      endcase
   end

   // Raw (pre-reset-gating) strobes
   logic pc_wr_raw, ir_wr_raw, reg_wr_raw, mem_wr_raw, done_raw;

   // Output decode from current state and instruction
   always_comb begin
      pc_wr_raw      = 1'b0;
      ir_wr_raw      = 1'b0;
      reg_wr_raw     = 1'b0;
      mem_wr_raw     = 1'b0;
      done_raw       = 1'b0;
      bus.reg_dst    = 2'b00;
      bus.alu_src    = 1'b0;
      bus.ext_op     = 1'b0;
      bus.alu_op     = 3'b000;
      bus.mem_to_reg = 2'b00;
      bus.npc_sel    = 2'b00;
      case (state_q)
         S_IF: begin
            ir_wr_raw = 1'b1;
            pc_wr_raw = 1'b1;
         end
         S_ID: begin
            if (is_j || is_jal) begin
               pc_wr_raw   = 1'b1;
               bus.npc_sel = 2'b10;
               done_raw    = 1'b1;
               if (is_jal) begin
                  reg_wr_raw     = 1'b1;
                  bus.reg_dst    = 2'b10;
                  bus.mem_to_reg = 2'b11;
               end
            end else if (is_jr) begin
               pc_wr_raw   = 1'b1;
               bus.npc_sel = 2'b11;
               done_raw    = 1'b1;
            end else if (!is_known) begin
               done_raw = 1'b1;
            end
         end
         S_EXE: begin
            if (is_ralu) begin
               bus.alu_op = is_subu ? 3'b001 : 3'b000;
            end else if (is_ori) begin
               bus.alu_src = 1'b1;
               bus.alu_op  = 3'b010;
            end else if (is_lw || is_sw) begin
               bus.alu_src = 1'b1;
               bus.ext_op  = 1'b1;
            end else if (is_beq) begin
               bus.alu_op  = 3'b001;
               bus.npc_sel = 2'b01;
               pc_wr_raw   = bus.zero;
               done_raw    = 1'b1;
            end else if (is_blez) begin
               bus.npc_sel = 2'b01;
               pc_wr_raw   = bus.lez;
               done_raw    = 1'b1;
            end
         end
         S_MEM: begin
            // Store commits only once the DM wait has elapsed
            if (is_sw && mem_last) begin
               mem_wr_raw = 1'b1;
               done_raw   = 1'b1;
            end
         end
         S_WB: begin
            reg_wr_raw = 1'b1;
            done_raw   = 1'b1;
            if (is_ralu) begin
               bus.reg_dst = 2'b01;
            end else if (is_lui) begin
               bus.mem_to_reg = 2'b01;
            end else if (is_lw) begin
               bus.mem_to_reg = 2'b10;
            end
         end
         default: ;
      endcase
   end

   // Strobes are suppressed while reset is held so an abandoned instruction
   // never commits a GRF/DM/PC write.
   assign bus.pc_wr      = pc_wr_raw  & ~reset;
   assign bus.ir_wr      = ir_wr_raw  & ~reset;
   assign bus.reg_wr     = reg_wr_raw & ~reset;
   assign bus.mem_wr     = mem_wr_raw & ~reset;
   assign bus.instr_done = done_raw   & ~reset;
   assign bus.state      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_ctrl
// Purpose  : Directed self-checking bench for mc_ctrl. Two instances share
//            stimulus: MEM_WAIT=0 (u_dut0) and MEM_WAIT=2 (u_dut2).
// Revision : 1.0
// ============================================================================
module tb_mc_ctrl;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   done_cnt;

   always #5 clk = ~clk;

   mc_ctrl_if i0 ();
   mc_ctrl_if i2 ();

   assign i2.op   = i0.op;
   assign i2.func = i0.func;
   assign i2.zero = i0.zero;
   assign i2.lez  = i0.lez;

   mc_ctrl #(.MEM_WAIT(0)) u_dut0 (.clk(clk), .reset(reset), .bus(i0.master));
   mc_ctrl #(.MEM_WAIT(2)) u_dut2 (.clk(clk), .reset(reset), .bus(i2.master));

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one cycle and sample away from the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Two-cycle reset; returns in the first S_IF cycle after release
   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
   endtask

   initial begin
      i0.op = 6'b000000; i0.func = 6'b100001; i0.zero = 1'b0; i0.lez = 1'b0;

      // ---- 1. reset, then addu ----
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_state", i0.state, 3'd0);
      check_val("rst_ir_wr", i0.ir_wr, 1'b0);
      check_val("rst_pc_wr", i0.pc_wr, 1'b0);
      reset = 1'b0;
      #1;
      done_cnt = 0;
      check_val("addu_if_state", i0.state, 3'd0);
      check_val("addu_if_irwr", i0.ir_wr, 1'b1);
      check_val("addu_if_pcwr", i0.pc_wr, 1'b1);
      check_val("addu_if_regwr", i0.reg_wr, 1'b0);
      done_cnt += i0.instr_done;
      step();
      check_val("addu_id_state", i0.state, 3'd1);
      check_val("addu_id_regwr", i0.reg_wr, 1'b0);
      done_cnt += i0.instr_done;
      step();
      check_val("addu_exe_state", i0.state, 3'd2);
      check_val("addu_exe_aluop", i0.alu_op, 3'b000);
      check_val("addu_exe_regwr", i0.reg_wr, 1'b0);
      done_cnt += i0.instr_done;
      step();
      check_val("addu_wb_state", i0.state, 3'd4);
      check_val("addu_wb_regwr", i0.reg_wr, 1'b1);
      check_val("addu_wb_regdst", i0.reg_dst, 2'b01);
      check_val("addu_wb_m2r", i0.mem_to_reg, 2'b00);
      done_cnt += i0.instr_done;
      step();
      check_val("addu_end_state", i0.state, 3'd0);
      check_val("addu_done_cnt", done_cnt, 1);

      // ---- subu ALU op ----
      do_reset();
      i0.func = 6'b100011;
      step(); step();
      check_val("subu_exe_aluop", i0.alu_op, 3'b001);

      // ---- ori ----
      do_reset();
      i0.op = 6'b001101;
      step(); step();
      check_val("ori_exe_src", {i0.alu_src, i0.ext_op, i0.alu_op}, 5'b1_0_010);
      step();
      check_val("ori_wb", {i0.state, i0.reg_wr, i0.reg_dst, i0.mem_to_reg}, {3'd4, 1'b1, 2'b00, 2'b00});

      // ---- lui ----
      do_reset();
      i0.op = 6'b001111;
      step(); step(); step();
      check_val("lui_wb", {i0.state, i0.reg_wr, i0.reg_dst, i0.mem_to_reg}, {3'd4, 1'b1, 2'b00, 2'b01});

      // ---- 2. beq taken then not taken ----
      do_reset();
      i0.op = 6'b000100; i0.zero = 1'b1;
      step();
      check_val("beq1_id_state", i0.state, 3'd1);
      step();
      check_val("beq1_exe", {i0.state, i0.pc_wr, i0.npc_sel, i0.alu_op, i0.instr_done},
                {3'd2, 1'b1, 2'b01, 3'b001, 1'b1});
      step();
      check_val("beq1_end_state", i0.state, 3'd0);
      i0.zero = 1'b0;
      step(); step();
      check_val("beq0_exe", {i0.state, i0.pc_wr, i0.npc_sel, i0.instr_done},
                {3'd2, 1'b0, 2'b01, 1'b1});
      step();
      check_val("beq0_end_state", i0.state, 3'd0);

      // ---- blez taken ----
      do_reset();
      i0.op = 6'b000110; i0.lez = 1'b1;
      step(); step();
      check_val("blez_exe", {i0.state, i0.pc_wr, i0.npc_sel, i0.instr_done},
                {3'd2, 1'b1, 2'b01, 1'b1});
      i0.lez = 1'b0;

      // ---- 3. sw, MEM_WAIT=2 on u_dut2 (and MEM_WAIT=0 on u_dut0) ----
      do_reset();
      i0.op = 6'b101011;
      step(); step();
      check_val("sw2_exe", {i2.state, i2.alu_src, i2.ext_op, i2.alu_op}, {3'd2, 1'b1, 1'b1, 3'b000});
      step();
      check_val("sw2_mem1", {i2.state, i2.mem_wr, i2.instr_done}, {3'd3, 1'b0, 1'b0});
      check_val("sw0_mem", {i0.state, i0.mem_wr, i0.instr_done}, {3'd3, 1'b1, 1'b1});
      step();
      check_val("sw2_mem2", {i2.state, i2.mem_wr, i2.instr_done}, {3'd3, 1'b0, 1'b0});
      step();
      check_val("sw2_mem3", {i2.state, i2.mem_wr, i2.instr_done}, {3'd3, 1'b1, 1'b1});
      step();
      check_val("sw2_end_state", i2.state, 3'd0);

      // ---- 4. lw, MEM_WAIT=0 ----
      do_reset();
      i0.op = 6'b100011;
      step(); step(); step();
      check_val("lw_mem", {i0.state, i0.reg_wr, i0.mem_wr, i0.instr_done}, {3'd3, 1'b0, 1'b0, 1'b0});
      step();
      check_val("lw_wb", {i0.state, i0.reg_wr, i0.mem_to_reg, i0.reg_dst, i0.instr_done},
                {3'd4, 1'b1, 2'b10, 2'b00, 1'b1});
      step();
      check_val("lw_end_state", i0.state, 3'd0);

      // ---- 5. jal, j, jr ----
      do_reset();
      i0.op = 6'b000011;
      step();
      check_val("jal_id", {i0.state, i0.pc_wr, i0.npc_sel, i0.reg_wr, i0.reg_dst, i0.mem_to_reg, i0.instr_done},
                {3'd1, 1'b1, 2'b10, 1'b1, 2'b10, 2'b11, 1'b1});
      step();
      check_val("jal_end_state", i0.state, 3'd0);
      i0.op = 6'b000010;
      step();
      check_val("j_id", {i0.state, i0.pc_wr, i0.npc_sel, i0.reg_wr, i0.instr_done},
                {3'd1, 1'b1, 2'b10, 1'b0, 1'b1});
      step();
      i0.op = 6'b000000; i0.func = 6'b001000;
      step();
      check_val("jr_id", {i0.state, i0.pc_wr, i0.npc_sel, i0.reg_wr, i0.instr_done},
                {3'd1, 1'b1, 2'b11, 1'b0, 1'b1});
      step();
      check_val("jr_end_state", i0.state, 3'd0);

      // ---- 6a. reset during final MEM cycle of sw (MEM_WAIT=2) ----
      do_reset();
      i0.op = 6'b101011;
      step(); step(); step(); step(); step();
      check_val("swrst_pre_state", i2.state, 3'd3);
      reset = 1'b1;
      #1;
      check_val("swrst_memwr", {i2.mem_wr, i2.instr_done}, 2'b00);
      step();
      check_val("swrst_state", i2.state, 3'd0);
      reset = 1'b0;
      #1;
      // Counter must restart from zero after the abandoned store
      step(); step(); step();
      check_val("swre_mem1", i2.mem_wr, 1'b0);
      step();
      check_val("swre_mem2", i2.mem_wr, 1'b0);
      step();
      check_val("swre_mem3", i2.mem_wr, 1'b1);

      // ---- 6b. unknown op 111111 runs as nop ----
      do_reset();
      i0.op = 6'b111111;
      check_val("nop_if", {i0.state, i0.ir_wr, i0.pc_wr}, {3'd0, 1'b1, 1'b1});
      step();
      check_val("nop_id", {i0.state, i0.pc_wr, i0.ir_wr, i0.reg_wr, i0.mem_wr, i0.instr_done},
                {3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
      step();
      check_val("nop_end_state", i0.state, 3'd0);

      // ---- R-type with unknown func also runs as nop ----
      i0.op = 6'b000000; i0.func = 6'b000000;
      step();
      check_val("rnop_id", {i0.state, i0.pc_wr, i0.reg_wr, i0.instr_done}, {3'd1, 1'b0, 1'b0, 1'b1});
      step();
      check_val("rnop_end_state", i0.state, 3'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
